energy_telemetry_tx: RTL and testbench
======================================

Name: energy_telemetry_tx

Overview:
- Transmit-side counterpart to the converter's 8-bit sample input path.
- Buffers 8-bit converter measurement samples (voltage/current/power codes) in a small FIFO.
- Wraps each sample in a 4-byte telemetry frame and serialises it on a UART 8N1 line.
- Sits between the measurement datapath and an output pin; the lab logger/host is the receiving end.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be >= 2.
- FIFO_DEPTH, 4, sample FIFO entries; power of two, >= 2.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- ena  in  1  frame-start enable; low blocks new frames, current frame completes.
- sample_in  in  8  measurement sample.
- sample_valid  in  1  sample_in valid.
- sample_ready  out  1  FIFO can accept; equals !full.
- tx  out  1  UART serial output, registered, idle high.
- busy  out  1  high from first start bit to end of last stop bit of a frame.
- frame_done  out  1  one-cycle pulse when a frame's final stop bit ends.
- seq_num  out  8  sequence number of the next frame to send.

Behaviour:
- Clock and reset:
  - Single clock; reset is asynchronous and active-high.
  - While rst is high: tx=1, busy=0, frame_done=0, seq_num=0, FIFO emptied, sample_ready=1.
- FIFO:
  - Push when sample_valid && sample_ready.
  - sample_ready = !full. Combinational on FIFO count; it does not look ahead to a same-cycle pop, so a full FIFO refuses a push even while popping.
  - A push into an empty FIFO is not poppable until the next cycle.
  - Order is preserved; no data loss; samples are never dropped.
- Frame format: SYNC_BYTE, SEQ, DATA, CHK.
  - CHK = (SEQ + DATA) mod 256.
  - Bytes go out in that order with no idle bits between bytes.
- Bit format:
  - Start bit 0, 8 data bits LSB first, stop bit 1.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - One byte = 10*CLKS_PER_BIT cycles; one frame = 40*CLKS_PER_BIT cycles.
- State machine: IDLE, START, DATA, STOP.
  - IDLE -> START: FIFO non-empty && ena in cycle N. Pop the FIFO, latch DATA and the current seq_num, byte index = 0. tx goes low at the edge ending cycle N (visible cycle N+1); busy rises at the same edge.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8*CLKS_PER_BIT cycles, with the bit index shifting each CLKS_PER_BIT.
  - STOP, byte index < 3: increment the index, then -> START.
  - STOP, byte index == 3: frame_done pulses on the last cycle of the stop bit. On the following edge seq_num increments (255 wraps to 0) and the FSM goes to IDLE. busy falls on that same edge.
  - Back-to-back frames: if FIFO non-empty && ena in the first IDLE cycle, the next start bit follows, giving exactly one idle-high cycle between frames.
- ena sampled only in IDLE; dropping it mid-frame has no effect on that frame.
- Reset mid-frame: the frame is abandoned and tx returns high immediately (async). After release the FSM is in IDLE with seq_num=0; no partial frame resumes.
- Bit counter and baud counter widths: clog2 of their ranges; no overflow beyond 40*CLKS_PER_BIT per frame.

Test Plan (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Single sample: after reset, push 0x96 (150) once with ena=1.
  - Decoded tx bytes: A5 00 96 96.
  - busy high for exactly 160 cycles; one frame_done pulse; seq_num becomes 1.
- Second sample: then push 0x2D (45).
  - Bytes: A5 01 2D 2E; seq_num becomes 2.
- FIFO full: sample_valid held high with 0x10,0x11,... from cycle 0.
  - Exactly 5 pushes accepted (0x10–0x14); sample_ready low from cycle 5.
  - Frames emitted in order with DATA 10,11,12,13,14 and one idle cycle between frames.
- Sequence wrap: send 257 frames with DATA=0x01.
  - Frame 256: SEQ=FF, CHK=00. Frame 257: SEQ=00, CHK=01.
- ena gating: ena=0, push 0x55.
  - tx stays 1 and busy 0 for 500 cycles; FIFO holds the sample.
  - Raise ena: frame A5 xx 55 (xx+55) starts within 2 cycles.
  - Drop ena mid-frame: that frame completes.
- Reset mid-frame: assert rst during DATA of byte 2.
  - tx=1 and busy=0 immediately; sample_ready=1; seq_num=0.
  - Next pushed sample 0x7F gives A5 00 7F 7F.

Source files
------------

// File: rtl/energy_telemetry_tx.sv
// ============================================================================
//  Module      : energy_telemetry_tx
//  Description : Sample FIFO feeding a UART 8N1 framer (SYNC, SEQ, DATA, CHK).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module energy_telemetry_tx #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] sample_in,
    input  logic       sample_valid,
    output logic       sample_ready,
    output logic       tx,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] seq_num
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [BAUD_W-1:0] c_baud_last = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]    c_fifo_full = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Sample FIFO
    // ------------------------------------------------------------------------
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign sample_ready = (r_count != c_fifo_full);
    assign w_push       = sample_valid && sample_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= sample_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Framer / serialiser
    // ------------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_next;
    logic [BAUD_W-1:0] r_baud;
    logic [BAUD_W-1:0] w_baud_next;
    logic [2:0]        r_bit_idx;
    logic [2:0]        w_bit_next;
    logic [1:0]        r_byte_idx;
    logic [1:0]        w_byte_next;
    logic [7:0]        r_data;
    logic [7:0]        w_data_next;
    logic [7:0]        r_seq;
    logic              w_seq_inc;
    logic              r_tx;
    logic              w_tx_next;
    logic [7:0]        w_cur_byte;
    logic              w_baud_end;

    assign w_baud_end = (r_baud == c_baud_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_data     <= '0;
            r_seq      <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_baud     <= w_baud_next;
            r_bit_idx  <= w_bit_next;
            r_byte_idx <= w_byte_next;
            r_data     <= w_data_next;
            r_tx       <= w_tx_next;
            if (w_seq_inc) begin
                r_seq <= r_seq + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit_idx;
        w_byte_next  = r_byte_idx;
        w_data_next  = r_data;
        w_seq_inc    = 1'b0;
        w_pop        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if ((r_count != '0) && ena) begin
                    w_pop        = 1'b1;
                    w_data_next  = r_mem[r_rd_ptr];
                    w_state_next = S_START;
                    w_baud_next  = '0;
                    w_byte_next  = '0;
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                    w_state_next = S_DATA;
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    w_baud_next = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_next = r_bit_idx + 1'b1;
                    end
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    w_baud_next = '0;
                    if (r_byte_idx == 2'd3) begin
                        w_state_next = S_IDLE;
                        w_seq_inc    = 1'b1;
                    end else begin
                        w_byte_next  = r_byte_idx + 1'b1;
                        w_state_next = S_START;
                    end
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // The line level is derived from the next state so tx itself stays a flop.
    always_comb begin
        case (w_byte_next)
            2'd0:    w_cur_byte = SYNC_BYTE;
            2'd1:    w_cur_byte = r_seq;
            2'd2:    w_cur_byte = w_data_next;
            default: w_cur_byte = r_seq + w_data_next;
        endcase

        case (w_state_next)
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = w_cur_byte[w_bit_next];
            default: w_tx_next = 1'b1;
        endcase
    end

    assign tx         = r_tx;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = (r_state == S_STOP) && w_baud_end && (r_byte_idx == 2'd3);
    assign seq_num    = r_seq;

endmodule

`default_nettype wire

// File: tb/tb_energy_telemetry_tx.sv
// ============================================================================
//  Module      : tb_energy_telemetry_tx
//  Description : Scoreboard bench; UART decoder monitor checks framed bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_energy_telemetry_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 40 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       sample_ready;
    logic       tx;
    logic       busy;
    logic       frame_done;
    logic [7:0] seq_num;

    always #5 clk = ~clk;

    energy_telemetry_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .tx           (tx),
        .busy         (busy),
        .frame_done   (frame_done),
        .seq_num      (seq_num)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: every accepted sample becomes one frame, in order.
    logic [7:0] exp_q[$];
    logic [7:0] seq_model;
    int         frames_model;
    bit         expect_b2b = 1'b0;

    int         dec = -1;
    logic [7:0] shreg;
    int         run;
    int         gap;
    bit         had_prev;
    bit         fd_seen;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            seq_model    = 8'd0;
            frames_model = 0;
            dec          = -1;
            run          = 0;
            gap          = 0;
            had_prev     = 1'b0;
            fd_seen      = 1'b0;
        end else begin
            if (sample_valid && sample_ready) begin
                exp_q.push_back(8'hA5);
                exp_q.push_back(seq_model);
                exp_q.push_back(sample_in);
                exp_q.push_back(8'(seq_model + sample_in));
                seq_model = seq_model + 8'd1;
            end

            if (dec < 0) begin
                if (tx == 1'b0) dec = 0;
            end else begin
                dec++;
                if (dec == CPB / 2) check_eq("start_bit", int'(tx), 0);
                for (int i = 0; i < 8; i++)
                    if (dec == CPB * (1 + i) + CPB / 2) shreg[i] = tx;
                if (dec == CPB * 9 + CPB / 2) begin
                    check_eq("stop_bit", int'(tx), 1);
                    if (exp_q.size() == 0) check_eq("unexpected_byte", int'(shreg), -1);
                    else check_eq("tx_byte", int'(shreg), int'(exp_q.pop_front()));
                    dec = -1;
                end
            end

            if (busy) begin
                if (run == 0) begin
                    if (expect_b2b && had_prev) check_eq("frame_gap", gap, 1);
                    fd_seen = 1'b0;
                end
                run++;
                if (frame_done) begin
                    check_eq("frame_done_pos", run, FRAME);
                    fd_seen = 1'b1;
                end
            end else begin
                check_eq("frame_done_idle", int'(frame_done), 0);
                if (run > 0) begin
                    check_eq("busy_len", run, FRAME);
                    check_eq("frame_done_seen", int'(fd_seen), 1);
                    frames_model++;
                    check_eq("seq_num", int'(seq_num), frames_model % 256);
                    had_prev = 1'b1;
                    gap      = 0;
                    run      = 0;
                end
                gap++;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        tick();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic push_one(input logic [7:0] d);
        int t = 0;
        sample_in    = d;
        sample_valid = 1'b1;
        @(negedge clk);
        while (!sample_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) check_eq("push_timeout", t, 0);
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int t = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy) && t < max) begin
            @(negedge clk);
            t++;
        end
        if (t >= max) check_eq("drain_timeout", exp_q.size(), 0);
        repeat (2) tick();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc;
        int sent;
        int t;
        int viol;

        rst          = 1'b1;
        ena          = 1'b1;
        sample_valid = 1'b0;
        sample_in    = 8'd0;

        @(negedge clk);
        @(negedge clk);
        check_eq("rst_tx", int'(tx), 1);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_frame_done", int'(frame_done), 0);
        check_eq("rst_seq", int'(seq_num), 0);
        check_eq("rst_ready", int'(sample_ready), 1);
        tick();
        rst = 1'b0;

        // Single samples: A5 00 96 96, then A5 01 2D 2E
        push_one(8'h96);
        wait_idle(1000);
        check_eq("seq_after_1", int'(seq_num), 1);
        push_one(8'h2D);
        wait_idle(1000);
        check_eq("seq_after_2", int'(seq_num), 2);

        // FIFO full with sample_valid held from cycle 0
        do_reset();
        expect_b2b   = 1'b1;
        acc          = 0;
        sample_valid = 1'b1;
        sample_in    = 8'h10;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (cyc == 4) check_eq("ready_c4", int'(sample_ready), 1);
            if (cyc == 5) check_eq("ready_c5", int'(sample_ready), 0);
            if (sample_ready) acc++;
            tick();
            sample_in = 8'(8'h10 + acc);
        end
        sample_valid = 1'b0;
        check_eq("fifo_accepted", acc, 5);
        wait_idle(5000);
        expect_b2b = 1'b0;
        check_eq("seq_after_fifo", int'(seq_num), 5);

        // Sequence wrap: 257 frames of DATA=0x01
        do_reset();
        sent         = 0;
        t            = 0;
        sample_in    = 8'h01;
        sample_valid = 1'b1;
        while (sent < 257 && t < 60000) begin
            @(negedge clk);
            if (sample_ready) sent++;
            tick();
            if (sent >= 257) sample_valid = 1'b0;
            t++;
        end
        sample_valid = 1'b0;
        check_eq("wrap_sent", sent, 257);
        wait_idle(2000);
        check_eq("seq_wrap", int'(seq_num), 1);

        // ena gating
        do_reset();
        ena = 1'b0;
        push_one(8'h55);
        viol = 0;
        repeat (500) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) viol++;
        end
        check_eq("ena_hold", viol, 0);
        check_eq("ena_fifo_held", exp_q.size(), 4);
        tick();
        ena = 1'b1;
        t   = 0;
        @(negedge clk);
        while (!busy && t < 10) begin
            @(negedge clk);
            t++;
        end
        check_eq("ena_start_lat", int'(t <= 2), 1);
        repeat (50) tick();
        ena = 1'b0;
        wait_idle(1000);
        ena = 1'b1;

        // Reset during DATA of byte 2
        push_one(8'h33);
        t = 0;
        while (!busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (90) @(negedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_tx", int'(tx), 1);
        check_eq("mid_rst_busy", int'(busy), 0);
        check_eq("mid_rst_ready", int'(sample_ready), 1);
        check_eq("mid_rst_seq", int'(seq_num), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        push_one(8'h7F);
        wait_idle(1000);
        check_eq("seq_after_rst", int'(seq_num), 1);

        // Randomised traffic with ena toggling
        repeat (300) begin
            sample_valid = ($urandom_range(0, 3) == 0);
            sample_in    = 8'($urandom);
            ena          = ($urandom_range(0, 7) != 0);
            tick();
        end
        sample_valid = 1'b0;
        ena          = 1'b1;
        wait_idle(20000);
        check_eq("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
